// File: rtl/vid_tim_meas_if.sv
// vid_tim_meas_if: sampled sync stream in, timing
// measurements and lock status out.
interface vid_tim_meas_if;
  logic        ena;
  logic        hsync_in;
  logic        vsync_in;
  logic [15:0] meas_hlen;
  logic [7:0]  meas_hsync;
  logic [15:0] meas_vlines;
  logic [7:0]  meas_vsync;
  logic        locked;
  logic        line_start;
  logic        frame_start;
  logic        err;

  modport master (
    output ena, hsync_in, vsync_in,
    input  meas_hlen, meas_hsync,
    input  meas_vlines, meas_vsync,
    input  locked, line_start,
    input  frame_start, err
  );

  modport slave (
    input  ena, hsync_in, vsync_in,
    output meas_hlen, meas_hsync,
    output meas_vlines, meas_vsync,
    output locked, line_start,
    output frame_start, err
  );
endinterface

// File: rtl/vid_tim_meas.sv
// vid_tim_meas: measures incoming hsync/vsync timing
// and declares lock once the line length is stable.
module vid_tim_meas #(
  parameter int unsigned LOCK_CNT = 2,
  parameter bit          SYNC_POL = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  vid_tim_meas_if.slave vif
);
  // LOCKED is the only state with bit 1 set
  localparam logic [1:0] S_SEARCH = 2'b00;
  localparam logic [1:0] S_CHECK  = 2'b01;
  localparam logic [1:0] S_LOCKED = 2'b10;
  localparam logic [4:0] LOCK_N   = 5'(LOCK_CNT);

  logic        hs, vs, hs_q, vs_q;
  logic        hs_rise, hs_fall;
  logic        vs_rise, vs_fall;
  logic [15:0] pix_cnt, line_cnt;
  logic [15:0] ref_len, len;
  logic [7:0]  hw_cnt, vw_cnt;
  logic [3:0]  mcnt;
  logic [1:0]  state;
  logic        first, fseen;
  logic        tmo, match;

  assign hs = vif.hsync_in ~^ SYNC_POL;
  assign vs = vif.vsync_in ~^ SYNC_POL;

  assign hs_rise = vif.ena & hs & ~hs_q;
  assign hs_fall = vif.ena & ~hs & hs_q;
  assign vs_rise = vif.ena & vs & ~vs_q;
  assign vs_fall = vif.ena & ~vs & vs_q;

  assign len = (pix_cnt == 16'hFFFF) ?
               16'hFFFF : pix_cnt + 16'd1;
  assign match = (len == ref_len);
  assign tmo = vif.ena & ~hs_rise &
               (pix_cnt == 16'hFFFE) &
               (state != S_SEARCH);

  assign vif.locked = state[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else if (vif.ena) begin
      hs_q <= hs;
      vs_q <= vs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= 16'd0;
    end else if (hs_rise) begin
      pix_cnt <= 16'd0;
    end else if (vif.ena && pix_cnt != 16'hFFFF) begin
      pix_cnt <= pix_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_cnt         <= 8'd0;
      vif.meas_hsync <= 8'd0;
    end else if (hs_fall) begin
      vif.meas_hsync <= hw_cnt;
      hw_cnt         <= 8'd0;
    end else if (vif.ena && hs && hw_cnt != 8'hFF) begin
      hw_cnt <= hw_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt        <= 16'd0;
      vif.meas_vlines <= 16'd0;
      fseen           <= 1'b0;
    end else begin
      if (vs_rise) begin
        line_cnt <= hs_rise ? 16'd1 : 16'd0;
        if (fseen) vif.meas_vlines <= line_cnt;
        fseen <= 1'b1;
      end else if (hs_rise && line_cnt != 16'hFFFF) begin
        line_cnt <= line_cnt + 16'd1;
      end
      if (tmo) fseen <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vw_cnt         <= 8'd0;
      vif.meas_vsync <= 8'd0;
    end else if (vs_fall) begin
      vif.meas_vsync <= vw_cnt;
      vw_cnt         <= 8'd0;
    end else if (hs_rise && vs && vw_cnt != 8'hFF) begin
      vw_cnt <= vw_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_SEARCH;
      first         <= 1'b0;
      ref_len       <= 16'd0;
      mcnt          <= 4'd0;
      vif.meas_hlen <= 16'd0;
    end else if (tmo) begin
      state <= S_SEARCH;
    end else if (hs_rise) begin
      unique case (state)
        S_SEARCH: begin
          state <= S_CHECK;
          first <= 1'b1;
        end
        S_CHECK: begin
          vif.meas_hlen <= len;
          if (first) begin
            ref_len <= len;
            mcnt    <= 4'd0;
            first   <= 1'b0;
          end else if (match) begin
            mcnt <= mcnt + 4'd1;
            if ({1'b0, mcnt} + 5'd1 == LOCK_N)
              state <= S_LOCKED;
          end else begin
            ref_len <= len;
            mcnt    <= 4'd0;
          end
        end
        S_LOCKED: begin
          vif.meas_hlen <= len;
          if (!match) begin
            ref_len <= len;
            mcnt    <= 4'd0;
            state   <= S_CHECK;
          end
        end
        default: state <= S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vif.line_start  <= 1'b0;
      vif.frame_start <= 1'b0;
      vif.err         <= 1'b0;
    end else begin
      vif.line_start  <= hs_rise;
      vif.frame_start <= vs_rise;
      vif.err <= tmo |
        (hs_rise & (state == S_LOCKED) & ~match);
    end
  end
endmodule

// File: tb/tb_vid_tim_meas.sv
// tb_vid_tim_meas: scoreboard bench, one active-high
// and one active-low DUT fed the same sync stream.
module tb_vid_tim_meas;
  typedef struct packed {
    logic        ls;
    logic        fs;
    logic        er;
    logic        lk;
    logic        cv;
    logic [15:0] hlen;
    logic [7:0]  hsync;
    logic [15:0] vlines;
    logic [7:0]  vsync;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  q0[$];
  ev_t  q1[$];

  always #5 clk = ~clk;

  vid_tim_meas_if vif0 ();
  vid_tim_meas_if vif1 ();

  vid_tim_meas #(.LOCK_CNT(2), .SYNC_POL(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .vif(vif0.slave)
  );
  vid_tim_meas #(.LOCK_CNT(2), .SYNC_POL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .vif(vif1.slave)
  );

  function automatic ev_t mk(
    input logic ls, fs, er, lk, cv,
    input logic [15:0] hl, input logic [7:0] hw,
    input logic [15:0] vl, input logic [7:0] vw);
    ev_t e;
    e = '{ls: ls, fs: fs, er: er, lk: lk, cv: cv,
          hlen: hl, hsync: hw, vlines: vl, vsync: vw};
    return e;
  endfunction

  task automatic cmp(input int d, input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s got %0h expected %0h",
               d, nm, act, exp);
    end
  endtask

  task automatic check(input int d, input ev_t a);
    ev_t  e;
    logic got;
    e = '0;
    got = 1'b0;
    if (d == 0 && q0.size() > 0) begin
      e = q0.pop_front();
      got = 1'b1;
    end
    if (d == 1 && q1.size() > 0) begin
      e = q1.pop_front();
      got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dut%0d unexpected_event got %h expected none",
               d, a);
    end else begin
      cmp(d, "pulses", 64'({a.ls, a.fs, a.er}),
          64'({e.ls, e.fs, e.er}));
      cmp(d, "locked", 64'(a.lk), 64'(e.lk));
      cmp(d, "meas_hlen", 64'(a.hlen), 64'(e.hlen));
      cmp(d, "meas_hsync", 64'(a.hsync), 64'(e.hsync));
      if (e.cv) begin
        cmp(d, "meas_vlines", 64'(a.vlines), 64'(e.vlines));
        cmp(d, "meas_vsync", 64'(a.vsync), 64'(e.vsync));
      end
    end
  endtask

  // monitor: every pulse on either DUT consumes one expected event
  always @(negedge clk) begin
    if (rst_n) begin
      if (vif0.line_start | vif0.frame_start | vif0.err)
        check(0, mk(vif0.line_start, vif0.frame_start,
                    vif0.err, vif0.locked, 1'b0,
                    vif0.meas_hlen, vif0.meas_hsync,
                    vif0.meas_vlines, vif0.meas_vsync));
      if (vif1.line_start | vif1.frame_start | vif1.err)
        check(1, mk(vif1.line_start, vif1.frame_start,
                    vif1.err, vif1.locked, 1'b0,
                    vif1.meas_hlen, vif1.meas_hsync,
                    vif1.meas_vlines, vif1.meas_vsync));
    end
  end

  task automatic push(input logic ls, fs, er, lk, cv,
                      input logic [15:0] hl,
                      input logic [7:0] hw,
                      input logic [15:0] vl,
                      input logic [7:0] vw);
    q0.push_back(mk(ls, fs, er, lk, cv, hl, hw, vl, vw));
    q1.push_back(mk(ls, fs, er, lk, cv, hl, hw, vl, vw));
  endtask

  task automatic drv(input logic e, input logic h,
                     input logic v);
    vif0.ena = e;
    vif1.ena = e;
    vif0.hsync_in = h;
    vif1.hsync_in = ~h;
    vif0.vsync_in = v;
    vif1.vsync_in = ~v;
    @(posedge clk);
    #1;
  endtask

  // one line: expected event for its starting hsync rise,
  // then per ena-cycles of stimulus
  task automatic line(input int per, input int hw,
                      input logic v, input logic thr,
                      input logic fs, er, lk,
                      input logic [15:0] hl,
                      input logic [7:0] hsy,
                      input logic cv,
                      input logic [15:0] vl,
                      input logic [7:0] vw);
    push(1'b1, fs, er, lk, cv, hl, hsy, vl, vw);
    for (int i = 0; i < per; i++) begin
      drv(1'b1, i < hw, v);
      if (thr) drv(1'b0, ~(i < hw), ~v);
    end
  endtask

  task automatic chk_zero(input string nm);
    cmp(0, nm, {vif0.meas_hlen, vif0.meas_hsync,
                vif0.meas_vlines, vif0.meas_vsync,
                vif0.locked, vif0.line_start,
                vif0.frame_start, vif0.err}, 64'd0);
    cmp(1, nm, {vif1.meas_hlen, vif1.meas_hsync,
                vif1.meas_vlines, vif1.meas_vsync,
                vif1.locked, vif1.line_start,
                vif1.frame_start, vif1.err}, 64'd0);
  endtask

  int per_c[6] = '{101, 100, 100, 100, 100, 100};
  logic lk_c[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic er_c[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  int hl_c[6] = '{100, 101, 100, 100, 100, 100};

  initial begin
    vif0.ena = 1'b0;
    vif1.ena = 1'b0;
    vif0.hsync_in = 1'b0;
    vif1.hsync_in = 1'b1;
    vif0.vsync_in = 1'b0;
    vif1.vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_outputs");
    rst_n = 1'b1;

    // lock: period 100, width 4
    for (int k = 1; k <= 6; k++)
      line(100, 4, 1'b0, 1'b0, 1'b0, 1'b0, k >= 4,
           (k == 1) ? 16'd0 : 16'd100,
           (k == 1) ? 8'd0 : 8'd4,
           1'b1, 16'd0, 8'd0);

    // frames: 10 lines, vsync active 2 lines
    for (int j = 0; j < 25; j++)
      line(100, 4, (j % 10) < 2, 1'b0,
           (j % 10) == 0, 1'b0, 1'b1, 16'd100, 8'd4,
           1'b1, (j >= 10) ? 16'd10 : 16'd0,
           (j >= 2) ? 8'd2 : 8'd0);

    // one 101-long line while locked, then relock
    for (int k = 0; k < 6; k++)
      line(per_c[k], 4, 1'b0, 1'b0, 1'b0, er_c[k],
           lk_c[k], 16'(hl_c[k]), 8'd4,
           1'b1, 16'd10, 8'd2);

    // hsync stops: timeout
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
         16'd100, 8'd4, 16'd10, 8'd2);
    for (int i = 0; i < 65600; i++)
      drv(1'b1, 1'b0, 1'b0);
    cmp(0, "locked_after_timeout", 64'(vif0.locked), 64'd0);
    cmp(1, "locked_after_timeout", 64'(vif1.locked), 64'd0);

    // back in SEARCH: first rise captures nothing
    line(90, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         16'd100, 8'd4, 1'b1, 16'd10, 8'd2);
    line(90, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         16'd90, 8'd4, 1'b1, 16'd10, 8'd2);
    line(50, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         16'd90, 8'd4, 1'b1, 16'd10, 8'd2);

    // reset mid-line
    rst_n = 1'b0;
    #2;
    chk_zero("midline_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // throttled enable, same lock stream
    for (int k = 1; k <= 6; k++)
      line(100, 4, 1'b0, 1'b1, 1'b0, 1'b0, k >= 4,
           (k == 1) ? 16'd0 : 16'd100,
           (k == 1) ? 8'd0 : 8'd4,
           1'b1, 16'd0, 8'd0);

    repeat (4) drv(1'b1, 1'b0, 1'b0);
    cmp(0, "leftover_events", 64'(q0.size()), 64'd0);
    cmp(1, "leftover_events", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
